decode_stage: RTL and testbench

// - ID stage of the 5-stage MIPS core. Takes the IF/ID instruction and drives rs/rt read addresses
//   to register_file. Applies same-cycle writeback bypass, detects load-use hazards, decodes

---
 rtl/mips_pkg.sv | 74 +++++++
 rtl/instr_decoder.sv | 100 ++++++++++
 rtl/decode_stage.sv | 109 ++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID stage: opcode/funct values, ALU op codes, instruction field
// positions and the decoded-instruction bundle passed from instr_decoder to decode_stage.
package mips_pkg;

   localparam int WORD_W = 32;
   localparam int GPR_AW = 5;

   localparam int OP_MSB = 31, OP_LSB = 26;
   localparam int RS_MSB = 25, RS_LSB = 21;
   localparam int RT_MSB = 20, RT_LSB = 16;
   localparam int RD_MSB = 15, RD_LSB = 11;
   localparam int SH_MSB = 10, SH_LSB = 6;
   localparam int FN_MSB = 5,  FN_LSB = 0;
   localparam int IMM_MSB = 15;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_ADDU = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_SUBU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_SLL  = 4'd10;
   localparam logic [3:0] ALU_SRL  = 4'd11;
   localparam logic [3:0] ALU_SRA  = 4'd12;
   localparam logic [3:0] ALU_LUI  = 4'd13;

   typedef struct packed {
      logic [GPR_AW-1:0] rs;
      logic [GPR_AW-1:0] rt;
      logic [4:0]        shamt;
      logic [GPR_AW-1:0] dest;
      logic [WORD_W-1:0] imm;
      logic [3:0]        alu_op;
      logic              alu_src_imm;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              illegal;
      logic              uses_rt;
   } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: fields, extended immediate, ALU op and control bits.
// No state; illegal encodings come out with every side-effect bit cleared.
module instr_decoder
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] instr,
   output dec_t              dec
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm16;

   assign opcode = instr[OP_MSB:OP_LSB];
   assign funct  = instr[FN_MSB:FN_LSB];
   assign imm16  = instr[IMM_MSB:0];

   always_comb begin
      dec             = '0;
      dec.rs          = instr[RS_MSB:RS_LSB];
      dec.rt          = instr[RT_MSB:RT_LSB];
      dec.shamt       = instr[SH_MSB:SH_LSB];
      dec.dest        = instr[RT_MSB:RT_LSB];
      dec.imm         = {{16{imm16[15]}}, imm16};
      dec.alu_op      = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            dec.dest      = instr[RD_MSB:RD_LSB];
            dec.uses_rt   = 1'b1;
            dec.reg_write = 1'b1;
            case (funct)
               FN_ADD:  dec.alu_op = ALU_ADD;
               FN_ADDU: dec.alu_op = ALU_ADDU;
               FN_SUB:  dec.alu_op = ALU_SUB;
               FN_SUBU: dec.alu_op = ALU_SUBU;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_XOR:  dec.alu_op = ALU_XOR;
               FN_NOR:  dec.alu_op = ALU_NOR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               FN_SLTU: dec.alu_op = ALU_SLTU;
               FN_SLL:  dec.alu_op = ALU_SLL;
               FN_SRL:  dec.alu_op = ALU_SRL;
               FN_SRA:  dec.alu_op = ALU_SRA;
               default: begin
                  dec.illegal   = 1'b1;
                  dec.reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
            case (opcode)
               OP_ADDI:  dec.alu_op = ALU_ADD;
               OP_ADDIU: dec.alu_op = ALU_ADDU;
               OP_SLTI:  dec.alu_op = ALU_SLT;
               default:  dec.alu_op = ALU_SLTU;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec.imm         = {16'h0, imm16};
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
            case (opcode)
               OP_ANDI: dec.alu_op = ALU_AND;
               OP_ORI:  dec.alu_op = ALU_OR;
               default: dec.alu_op = ALU_XOR;
            endcase
         end
         OP_LUI: begin
            dec.imm         = {imm16, 16'h0};
            dec.alu_op      = ALU_LUI;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OP_LW: begin
            dec.alu_op      = ALU_ADDU;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
            dec.mem_read    = 1'b1;
         end
         OP_SW: begin
            dec.alu_op      = ALU_ADDU;
            dec.alu_src_imm = 1'b1;
            dec.mem_write   = 1'b1;
            dec.uses_rt     = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.alu_op  = ALU_SUBU;
            dec.uses_rt = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // $0 is hardwired, so a write to it is architecturally a no-op
      if (dec.dest == '0)
         dec.reg_write = 1'b0;
   end

endmodule

// File: rtl/decode_stage.sv
// ID stage: writeback bypass, load-use detection, decode; 1-cycle latency into ID/EX.
// ex_stall holds ID/EX and raises id_stall; a load-use hazard inserts a single bubble.
module decode_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc_plus4,
   input  logic              flush,
   input  logic              ex_stall,
   input  logic              wb_w_en,
   input  logic [REG_AW-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] rf_rd_addr_rs,
   output logic [REG_AW-1:0] rf_rd_addr_rt,
   input  logic [DATA_W-1:0] rf_data_rs,
   input  logic [DATA_W-1:0] rf_data_rt,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_shamt,
   output logic [REG_AW-1:0] ex_dest,
   output logic [3:0]        ex_alu_op,
   output logic              ex_alu_src_imm,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_illegal,
   output logic [31:0]       ex_pc_plus4
);

   dec_t              dec;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic              haz;

   instr_decoder u_instr_decoder (
      .instr (if_instr),
      .dec   (dec)
   );

   assign rf_rd_addr_rs = dec.rs;
   assign rf_rd_addr_rt = dec.rt;

   // register_file commits at the same edge that ID/EX captures, so a same-cycle write must be bypassed
   function automatic logic [DATA_W-1:0] pick_operand(input logic [REG_AW-1:0] addr,
                                                      input logic [DATA_W-1:0] rf_val);
      if (addr == '0)
         return '0;
      else if (wb_w_en && (wb_waddr == addr))
         return wb_data;
      else
         return rf_val;
   endfunction

   assign rs_val = pick_operand(dec.rs, rf_data_rs);
   assign rt_val = pick_operand(dec.rt, rf_data_rt);

   assign haz = ex_valid && ex_mem_read && (ex_dest != '0) &&
                ((ex_dest == dec.rs) || (dec.uses_rt && (ex_dest == dec.rt)));

   assign id_stall = ex_stall | (if_valid & haz & ~flush);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         ex_valid       <= 1'b0;
         ex_rs_data     <= '0;
         ex_rt_data     <= '0;
         ex_imm         <= '0;
         ex_shamt       <= '0;
         ex_dest        <= '0;
         ex_alu_op      <= '0;
         ex_alu_src_imm <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_illegal     <= 1'b0;
         ex_pc_plus4    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!ex_stall) begin
         if (haz) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid       <= if_valid;
            ex_rs_data     <= rs_val;
            ex_rt_data     <= rt_val;
            ex_imm         <= dec.imm;
            ex_shamt       <= dec.shamt;
            ex_dest        <= dec.dest;
            ex_alu_op      <= dec.alu_op;
            ex_alu_src_imm <= dec.alu_src_imm;
            ex_reg_write   <= dec.reg_write;
            ex_mem_read    <= dec.mem_read;
            ex_mem_write   <= dec.mem_write;
            ex_illegal     <= dec.illegal;
            ex_pc_plus4    <= if_pc_plus4;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed table of ID-stage vectors with hand-computed ID/EX contents, plus an async reset sequence.
module tb_decode_stage;
   import mips_pkg::*;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam logic [31:0] A  = 32'h1111_1111;
   localparam logic [31:0] B  = 32'h2222_2222;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam int NV = 30;

   typedef struct {
      logic        vld;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        flush;
      logic        stall;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        e_stall;
      logic        e_valid;
      logic        chk;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic [31:0] e_imm;
      logic [4:0]  e_shamt;
      logic [4:0]  e_dest;
      logic [3:0]  e_op;
      logic        e_src;
      logic        e_rw;
      logic        e_mr;
      logic        e_mw;
      logic        e_ill;
      logic [31:0] e_pc4;
   } vec_t;

   logic        clock;
   logic        nreset;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc_plus4;
   logic        flush;
   logic        ex_stall;
   logic        wb_w_en;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_data;
   logic [4:0]  rf_rd_addr_rs;
   logic [4:0]  rf_rd_addr_rt;
   logic [31:0] rf_data_rs;
   logic [31:0] rf_data_rt;
   logic        id_stall;
   logic        ex_valid;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_shamt;
   logic [4:0]  ex_dest;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src_imm;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_illegal;
   logic [31:0] ex_pc_plus4;

   int n_checks = 0;
   int n_errors = 0;
   vec_t tbl [NV];

   decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clock          (clock),
      .nreset         (nreset),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc_plus4    (if_pc_plus4),
      .flush          (flush),
      .ex_stall       (ex_stall),
      .wb_w_en        (wb_w_en),
      .wb_waddr       (wb_waddr),
      .wb_data        (wb_data),
      .rf_rd_addr_rs  (rf_rd_addr_rs),
      .rf_rd_addr_rt  (rf_rd_addr_rt),
      .rf_data_rs     (rf_data_rs),
      .rf_data_rt     (rf_data_rt),
      .id_stall       (id_stall),
      .ex_valid       (ex_valid),
      .ex_rs_data     (ex_rs_data),
      .ex_rt_data     (ex_rt_data),
      .ex_imm         (ex_imm),
      .ex_shamt       (ex_shamt),
      .ex_dest        (ex_dest),
      .ex_alu_op      (ex_alu_op),
      .ex_alu_src_imm (ex_alu_src_imm),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_illegal     (ex_illegal),
      .ex_pc_plus4    (ex_pc_plus4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t issue(input logic [31:0] instr, input logic [31:0] pc4,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] imm, input logic [4:0] sh,
                                  input logic [4:0] dest, input logic [3:0] op,
                                  input logic src, input logic rw, input logic mr,
                                  input logic mw, input logic ill);
      vec_t v;
      v = '{vld: T, instr: instr, pc4: pc4, flush: F, stall: F, wen: F, waddr: 5'd0,
            wdata: 32'h0, e_stall: F, e_valid: T, chk: T, e_rs: rs, e_rt: rt, e_imm: imm,
            e_shamt: sh, e_dest: dest, e_op: op, e_src: src, e_rw: rw, e_mr: mr, e_mw: mw,
            e_ill: ill, e_pc4: pc4};
      return v;
   endfunction

   function automatic vec_t bubble(input logic [31:0] instr, input logic [31:0] pc4);
      vec_t v;
      v = issue(instr, pc4, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, ALU_ADD, F, F, F, F, F);
      v.e_stall = T;
      v.e_valid = F;
      v.chk     = F;
      return v;
   endfunction

   task automatic run(input vec_t v, input int idx);
      logic [31:0] ins;
      @(negedge clock);
      if_valid    = v.vld;
      if_instr    = v.instr;
      if_pc_plus4 = v.pc4;
      flush       = v.flush;
      ex_stall    = v.stall;
      wb_w_en     = v.wen;
      wb_waddr    = v.waddr;
      wb_data     = v.wdata;
      ins         = v.instr;
      #1;
      check($sformatf("r%0d id_stall", idx), 32'(id_stall), 32'(v.e_stall));
      check($sformatf("r%0d rd_addr_rs", idx), 32'(rf_rd_addr_rs), 32'(ins[25:21]));
      check($sformatf("r%0d rd_addr_rt", idx), 32'(rf_rd_addr_rt), 32'(ins[20:16]));
      @(posedge clock);
      #1;
      check($sformatf("r%0d ex_valid", idx), 32'(ex_valid), 32'(v.e_valid));
      if (v.chk) begin
         check($sformatf("r%0d ex_rs_data", idx), ex_rs_data, v.e_rs);
         check($sformatf("r%0d ex_rt_data", idx), ex_rt_data, v.e_rt);
         check($sformatf("r%0d ex_imm", idx), ex_imm, v.e_imm);
         check($sformatf("r%0d ex_shamt", idx), 32'(ex_shamt), 32'(v.e_shamt));
         check($sformatf("r%0d ex_dest", idx), 32'(ex_dest), 32'(v.e_dest));
         check($sformatf("r%0d ex_alu_op", idx), 32'(ex_alu_op), 32'(v.e_op));
         check($sformatf("r%0d ex_alu_src_imm", idx), 32'(ex_alu_src_imm), 32'(v.e_src));
         check($sformatf("r%0d ex_reg_write", idx), 32'(ex_reg_write), 32'(v.e_rw));
         check($sformatf("r%0d ex_mem_read", idx), 32'(ex_mem_read), 32'(v.e_mr));
         check($sformatf("r%0d ex_mem_write", idx), 32'(ex_mem_write), 32'(v.e_mw));
         check($sformatf("r%0d ex_illegal", idx), 32'(ex_illegal), 32'(v.e_ill));
         check($sformatf("r%0d ex_pc_plus4", idx), ex_pc_plus4, v.e_pc4);
      end
   endtask

   initial begin
      vec_t lw2;
      vec_t v;

      nreset      = 1'b0;
      if_valid    = 1'b0;
      if_instr    = 32'h0;
      if_pc_plus4 = 32'h0;
      flush       = 1'b0;
      ex_stall    = 1'b0;
      wb_w_en     = 1'b0;
      wb_waddr    = 5'd0;
      wb_data     = 32'h0;
      rf_data_rs  = A;
      rf_data_rt  = B;

      // lw $2,0($1) reused at several PCs
      lw2 = issue(32'h8C22_0000, 32'h0, A, B, 32'h0, 5'd0, 5'd2, ALU_ADDU, T, T, T, F, F);

      tbl[0]  = issue(32'h2003_0005, 32'h104, 32'h0, B, 32'h5, 5'd0, 5'd3, ALU_ADD, T, T, F, F, F);
      tbl[1]  = issue(32'h0084_2820, 32'h108, DB, DB, 32'h2820, 5'd0, 5'd5, ALU_ADD, F, T, F, F, F);
      tbl[1].wen = T; tbl[1].waddr = 5'd4; tbl[1].wdata = DB;
      tbl[2]  = issue(32'h0084_2820, 32'h10C, A, B, 32'h2820, 5'd0, 5'd5, ALU_ADD, F, T, F, F, F);
      tbl[2].wen = F; tbl[2].waddr = 5'd4; tbl[2].wdata = DB;
      tbl[3]  = issue(32'h0084_2820, 32'h110, A, B, 32'h2820, 5'd0, 5'd5, ALU_ADD, F, T, F, F, F);
      tbl[3].wen = T; tbl[3].waddr = 5'd5; tbl[3].wdata = DB;
      tbl[4]  = lw2; tbl[4].pc4 = 32'h114; tbl[4].e_pc4 = 32'h114;
      tbl[5]  = bubble(32'h0047_3020, 32'h118);
      tbl[6]  = issue(32'h0047_3020, 32'h118, A, B, 32'h3020, 5'd0, 5'd6, ALU_ADD, F, T, F, F, F);
      tbl[7]  = lw2; tbl[7].pc4 = 32'h11C; tbl[7].e_pc4 = 32'h11C;
      tbl[8]  = issue(32'h20E2_0001, 32'h120, A, B, 32'h1, 5'd0, 5'd2, ALU_ADD, T, T, F, F, F);
      tbl[9]  = lw2; tbl[9].pc4 = 32'h124; tbl[9].e_pc4 = 32'h124;
      tbl[10] = tbl[9];
      tbl[10].instr = 32'h0047_3020; tbl[10].pc4 = 32'h128; tbl[10].flush = T; tbl[10].e_valid = F;
      tbl[11] = issue(32'h8C20_0000, 32'h12C, A, 32'h0, 32'h0, 5'd0, 5'd0, ALU_ADDU, T, F, T, F, F);
      tbl[12] = issue(32'h0000_3020, 32'h130, 32'h0, 32'h0, 32'h3020, 5'd0, 5'd6, ALU_ADD, F, T, F, F, F);
      tbl[13] = issue(32'hFC00_0000, 32'h134, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, ALU_ADD, F, F, F, F, T);
      tbl[14] = issue(32'h0000_0001, 32'h138, 32'h0, 32'h0, 32'h1, 5'd0, 5'd0, ALU_ADD, F, F, F, F, T);
      tbl[15] = issue(32'h3024_8000, 32'h13C, A, B, 32'h0000_8000, 5'd0, 5'd4, ALU_AND, T, T, F, F, F);
      tbl[16] = issue(32'h2024_8000, 32'h140, A, B, 32'hFFFF_8000, 5'd0, 5'd4, ALU_ADD, T, T, F, F, F);
      tbl[17] = issue(32'h3C07_1234, 32'h144, 32'h0, B, 32'h1234_0000, 5'd8, 5'd7, ALU_LUI, T, T, F, F, F);
      tbl[18] = issue(32'hAC45_0008, 32'h148, A, B, 32'h8, 5'd0, 5'd5, ALU_ADDU, T, F, F, T, F);
      tbl[19] = issue(32'h0002_1900, 32'h14C, 32'h0, B, 32'h1900, 5'd4, 5'd3, ALU_SLL, F, T, F, F, F);
      for (int i = 20; i < 23; i++) begin
         tbl[i] = tbl[19];
         tbl[i].instr = 32'h2003_0005; tbl[i].pc4 = 32'h150; tbl[i].stall = T; tbl[i].e_stall = T;
      end
      tbl[23] = tbl[19];
      tbl[23].instr = 32'h2003_0005; tbl[23].pc4 = 32'h154;
      tbl[23].flush = T; tbl[23].stall = T; tbl[23].e_stall = T; tbl[23].e_valid = F;
      tbl[24] = lw2; tbl[24].pc4 = 32'h158; tbl[24].e_pc4 = 32'h158;
      tbl[25] = bubble(32'h00E2_3020, 32'h15C);
      tbl[26] = issue(32'h00E2_3020, 32'h15C, A, B, 32'h3020, 5'd0, 5'd6, ALU_ADD, F, T, F, F, F);
      tbl[27] = lw2; tbl[27].pc4 = 32'h160; tbl[27].e_pc4 = 32'h160;
      tbl[28] = bubble(32'h0047_3020, 32'h164);
      tbl[28].vld = F; tbl[28].e_stall = F;
      tbl[29] = issue(32'h0047_3020, 32'h164, A, B, 32'h3020, 5'd0, 5'd6, ALU_ADD, F, T, F, F, F);

      #12;
      check("reset ex_valid", 32'(ex_valid), 32'h0);
      check("reset ex_imm", ex_imm, 32'h0);
      check("reset ex_reg_write", 32'(ex_reg_write), 32'h0);
      check("reset ex_pc_plus4", ex_pc_plus4, 32'h0);
      @(negedge clock);
      nreset = 1'b1;

      for (int i = 0; i < NV; i++)
         run(tbl[i], i);

      // Async reset in the middle of a cycle with a valid instruction in ID/EX
      v = issue(32'h2003_0005, 32'h200, 32'h0, B, 32'h5, 5'd0, 5'd3, ALU_ADD, T, T, F, F, F);
      run(v, 100);
      #2;
      nreset = 1'b0;
      #1;
      check("midreset ex_valid", 32'(ex_valid), 32'h0);
      check("midreset ex_imm", ex_imm, 32'h0);
      check("midreset ex_dest", 32'(ex_dest), 32'h0);
      check("midreset ex_reg_write", 32'(ex_reg_write), 32'h0);
      check("midreset ex_pc_plus4", ex_pc_plus4, 32'h0);
      if_valid = 1'b0;
      @(negedge clock);
      nreset = 1'b1;
      v = bubble(32'h0000_0000, 32'h204);
      v.vld = F; v.e_stall = F;
      run(v, 101);
      v = issue(32'h2003_0005, 32'h208, 32'h0, B, 32'h5, 5'd0, 5'd3, ALU_ADD, T, T, F, F, F);
      run(v, 102);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
